// File: rtl/ram_fifo_pkg.sv
// Shared defaults and the per-cycle operation type for the RAM-backed FIFO controller.
package ram_fifo_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 6;
    localparam int unsigned DEPTH_DEF  = 2 ** ADDR_W_DEF;

    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } op_e;

endpackage

// File: rtl/ram_fifo_ptr.sv
// ADDR_W-bit wrapping FIFO pointer with synchronous clear.
module ram_fifo_ptr
    import ram_fifo_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inc,
    input  logic              clr,
    output logic [ADDR_W-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller for an external dual-port RAM with 1-cycle registered read.
// Optional almost_full/almost_empty outputs under `RAM_FIFO_CTRL_ALMOST_EN.
module ram_fifo_ctrl
    import ram_fifo_pkg::*;
#(
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned AFULL_TH  = DEPTH_DEF - 8,
    parameter int unsigned AEMPTY_TH = DEPTH_DEF / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_req,
    input  logic              flush,
    input  logic              clr_err,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              ovf,
    output logic              udf,
    output logic              ram_cs,
    output logic              ram_we_a,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic [DATA_W-1:0] ram_din_a,
    output logic              ram_re_b,
    output logic [ADDR_W-1:0] ram_addr_b,
    input  logic [DATA_W-1:0] ram_dout_b
`ifdef RAM_FIFO_CTRL_ALMOST_EN
    ,
    output logic              almost_full,
    output logic              almost_empty
`endif
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push_ok;
    logic              pop_ok;
    logic              push_rej;
    logic              pop_rej;
    logic              valid_q;
    logic [CNT_W-1:0]  cnt_next;
    op_e               op;

    always_comb begin
        push_ok  = 1'b0;
        pop_ok   = 1'b0;
        push_rej = 1'b0;
        pop_rej  = 1'b0;
        if (!rst && !flush) begin
            push_ok  = wr_req && !full;
            pop_ok   = rd_req && !empty;
            push_rej = wr_req && full;
            pop_rej  = rd_req && empty;
        end
        op = op_e'({pop_ok, push_ok});
        cnt_next = count;
        unique case (op)
            OP_PUSH: cnt_next = count + CNT_W'(1);
            OP_POP:  cnt_next = count - CNT_W'(1);
            default: cnt_next = count;
        endcase
        if (flush) begin
            cnt_next = '0;
        end
    end

    ram_fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (push_ok),
        .clr (flush),
        .ptr (wr_ptr)
    );

    ram_fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (pop_ok),
        .clr (flush),
        .ptr (rd_ptr)
    );

    assign ram_cs     = !rst;
    assign ram_we_a   = push_ok;
    assign ram_addr_a = wr_ptr;
    assign ram_din_a  = wr_data;
    assign ram_re_b   = pop_ok;
    assign ram_addr_b = rd_ptr;
    assign rd_data    = ram_dout_b;
    // A pop accepted just before rst/flush must not surface as valid data.
    assign rd_valid   = valid_q && !rst && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            empty   <= 1'b1;
            full    <= 1'b0;
            valid_q <= 1'b0;
            ovf     <= 1'b0;
            udf     <= 1'b0;
        end else begin
            count   <= cnt_next;
            empty   <= (cnt_next == '0);
            full    <= (cnt_next == CNT_W'(DEPTH));
            valid_q <= pop_ok;
            if (push_rej) begin
                ovf <= 1'b1;
            end else if (clr_err) begin
                ovf <= 1'b0;
            end
            if (pop_rej) begin
                udf <= 1'b1;
            end else if (clr_err) begin
                udf <= 1'b0;
            end
        end
    end

`ifdef RAM_FIFO_CTRL_ALMOST_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= (cnt_next >= CNT_W'(AFULL_TH));
            almost_empty <= (cnt_next <= CNT_W'(AEMPTY_TH));
        end
    end
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl: queue-based FIFO model plus a registered-read RAM.
module tb_ram_fifo_ctrl;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_req;
    logic [DATA_W-1:0] wr_data;
    logic              rd_req;
    logic              flush;
    logic              clr_err;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              ovf;
    logic              udf;
    logic              ram_cs;
    logic              ram_we_a;
    logic [ADDR_W-1:0] ram_addr_a;
    logic [DATA_W-1:0] ram_din_a;
    logic              ram_re_b;
    logic [ADDR_W-1:0] ram_addr_b;
    logic [DATA_W-1:0] ram_dout_b;
`ifdef RAM_FIFO_CTRL_ALMOST_EN
    logic              almost_full;
    logic              almost_empty;
`endif

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem [DEPTH];

    always @(posedge clk) begin
        if (ram_cs && ram_we_a) mem[ram_addr_a] <= ram_din_a;
        if (ram_cs && ram_re_b) ram_dout_b <= mem[ram_addr_b];
    end

    ram_fifo_ctrl #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .AFULL_TH  (56),
        .AEMPTY_TH (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_req     (wr_req),
        .wr_data    (wr_data),
        .rd_req     (rd_req),
        .flush      (flush),
        .clr_err    (clr_err),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .ovf        (ovf),
        .udf        (udf),
        .ram_cs     (ram_cs),
        .ram_we_a   (ram_we_a),
        .ram_addr_a (ram_addr_a),
        .ram_din_a  (ram_din_a),
        .ram_re_b   (ram_re_b),
        .ram_addr_b (ram_addr_b),
        .ram_dout_b (ram_dout_b)
`ifdef RAM_FIFO_CTRL_ALMOST_EN
        ,
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`endif
    );

    int passed = 0;
    int failed = 0;
    int total  = 0;

    logic [DATA_W-1:0] q [$];
    int                wptr;
    int                rptr;
    bit                m_ovf;
    bit                m_udf;
    bit                m_valid;
    logic [DATA_W-1:0] m_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic post_checks();
        check("count", count, q.size());
        check("empty", empty, q.size() == 0);
        check("full", full, q.size() == DEPTH);
        check("rd_valid", rd_valid, m_valid);
        if (m_valid) check("rd_data", rd_data, m_data);
        check("ovf", ovf, m_ovf);
        check("udf", udf, m_udf);
        check("wr_ptr", ram_addr_a, wptr);
        check("rd_ptr", ram_addr_b, rptr);
`ifdef RAM_FIFO_CTRL_ALMOST_EN
        check("almost_full", almost_full, q.size() >= 56);
        check("almost_empty", almost_empty, q.size() <= 8);
`endif
    endtask

    task automatic cycle(input bit wr, input logic [DATA_W-1:0] wd, input bit rd,
                         input bit fl, input bit ce);
        bit pok, qok, prej, qrej;
        wr_req  = wr;
        wr_data = wd;
        rd_req  = rd;
        flush   = fl;
        clr_err = ce;
        pok  = wr && !fl && (q.size() < DEPTH);
        qok  = rd && !fl && (q.size() > 0);
        prej = wr && !fl && (q.size() == DEPTH);
        qrej = rd && !fl && (q.size() == 0);
        #1;
        check("ram_cs", ram_cs, 1);
        check("ram_we_a", ram_we_a, pok);
        check("ram_re_b", ram_re_b, qok);
        if (pok) check("ram_din_a", ram_din_a, wd);
        @(posedge clk);
        #1;
        m_valid = qok;
        if (qok) m_data = q.pop_front();
        if (pok) q.push_back(wd);
        if (fl) begin
            q.delete();
            wptr = 0;
            rptr = 0;
        end else begin
            if (pok) wptr = (wptr + 1) % DEPTH;
            if (qok) rptr = (rptr + 1) % DEPTH;
        end
        if (prej) m_ovf = 1'b1;
        else if (ce) m_ovf = 1'b0;
        if (qrej) m_udf = 1'b1;
        else if (ce) m_udf = 1'b0;
        post_checks();
    endtask

    // busy=1 holds every other control input high to show rst wins over them.
    task automatic do_reset(input bit busy);
        rst     = 1'b1;
        wr_req  = busy;
        rd_req  = busy;
        flush   = busy;
        clr_err = busy;
        wr_data = 8'h5A;
        #1;
        check("rst_rd_valid", rd_valid, 0);
        check("rst_ram_cs", ram_cs, 0);
        check("rst_ram_we_a", ram_we_a, 0);
        check("rst_ram_re_b", ram_re_b, 0);
        @(posedge clk);
        #1;
        q.delete();
        wptr = 0;
        rptr = 0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
        m_valid = 1'b0;
        post_checks();
        rst     = 1'b0;
        wr_req  = 1'b0;
        rd_req  = 1'b0;
        flush   = 1'b0;
        clr_err = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] d;
        int unsigned r;

        do_reset(1'b0);

        // Fill 0x00..0x3F, then one rejected push.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, DATA_W'(i), 1'b0, 1'b0, 1'b0);
        check("fill_full", full, 1);
        check("fill_count", count, 64);
        check("fill_ovf", ovf, 0);
        cycle(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        check("ovf_set", ovf, 1);
        check("mem0_kept", mem[0], 8'h00);

        // Drain in order, then an extra pop.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
            check("drain_order", rd_data, DATA_W'(i));
        end
        check("drain_empty", empty, 1);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("udf_set", udf, 1);
        check("udf_no_valid", rd_valid, 0);

        // Rejected pop with clr_err: udf set wins, ovf clears.
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        check("set_wins", udf, 1);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);

        // Simultaneous push/pop at count=10 and at full.
        for (int i = 0; i < 10; i++) cycle(1'b1, DATA_W'($urandom), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, DATA_W'($urandom), 1'b1, 1'b0, 1'b0);
        check("both_cnt10", count, 10);
        while (q.size() < DEPTH) cycle(1'b1, DATA_W'($urandom), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, DATA_W'($urandom), 1'b1, 1'b0, 1'b0);
        check("both_full_cnt", count, 63);
        check("both_full_ovf", ovf, 1);

        // Move pointers to 60 and run 100 push/pop pairs across the wrap.
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 60; i++) cycle(1'b1, DATA_W'($urandom), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 60; i++) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("wrap_start", ram_addr_a, 60);
        cycle(1'b1, DATA_W'($urandom), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) cycle(1'b1, DATA_W'($urandom), 1'b1, 1'b0, 1'b0);
        check("wrap_rd_ptr", ram_addr_b, (60 + 100) % DEPTH);

        // Random mixed traffic.
        for (int i = 0; i < 400; i++) begin
            r = $urandom;
            d = DATA_W'($urandom);
            cycle(r[2:0] < 3'd5, d, r[5:3] < 3'd4, r[11:6] == 6'd0, r[15:12] == 4'd0);
        end

        // Flush at count=20 with rd_req and wr_req asserted; error flags must survive.
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b1, DATA_W'($urandom), 1'b0, 1'b0, 1'b0);
        check("pre_flush_cnt", count, 20);
        cycle(1'b1, DATA_W'($urandom), 1'b1, 1'b1, 1'b0);
        check("flush_cnt", count, 0);
        check("flush_empty", empty, 1);
        check("flush_udf", udf, 1);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("flush_no_valid", rd_valid, 0);

        // Reset the cycle after an accepted pop.
        for (int i = 0; i < 3; i++) cycle(1'b1, DATA_W'($urandom), 1'b0, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        do_reset(1'b1);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("post_rst_valid", rd_valid, 0);
        check("post_rst_empty", empty, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
